// File: rtl/div16x8_seq.sv
// Sequential restoring divider: 16-bit dividend / 8-bit divisor, one quotient bit per clock.
// FSM state is exported as a code and as a seven-segment digit.
module div16x8_seq #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        done_flag,
  output logic        div_by_zero,
  output logic [2:0]  state_out,
  output logic        seg_a,
  output logic        seg_b,
  output logic        seg_c,
  output logic        seg_d,
  output logic        seg_e,
  output logic        seg_f,
  output logic        seg_g
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] CALC = 3'd1;
  localparam logic [2:0] DONE = 3'd2;
  localparam logic [2:0] ERR  = 3'd3;

  logic [2:0]  state;
  logic        start_d;
  logic [15:0] q_w;
  logic [7:0]  r_w;
  logic [7:0]  d_w;
  logic [3:0]  cnt;

  logic        capture;
  logic [8:0]  t;
  logic [8:0]  diff;
  logic        ge;
  logic [15:0] q_next;
  logic [7:0]  r_next;
  logic [6:0]  seg_raw;

  assign capture = start & ~start_d & (state == IDLE);

  // One restoring step: shift the next dividend bit into the partial remainder.
  // When the compare fails, t < divisor <= 255, so t[8] is zero and dropping it is safe.
  always_comb begin
    t      = {r_w, q_w[15]};
    diff   = t - {1'b0, d_w};
    ge     = (t >= {1'b0, d_w});
    q_next = {q_w[14:0], ge};
    r_next = ge ? diff[7:0] : t[7:0];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= IDLE;
      start_d     <= 1'b0;
      q_w         <= '0;
      r_w         <= '0;
      d_w         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      done_flag   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      start_d   <= start;
      done_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            div_by_zero <= 1'b0;
            if (divisor != 8'd0) begin
              q_w   <= dividend;
              r_w   <= 8'd0;
              d_w   <= divisor;
              cnt   <= 4'd0;
              state <= CALC;
            end else begin
              quotient    <= 16'hFFFF;
              remainder   <= 8'hFF;
              div_by_zero <= 1'b1;
              done_flag   <= 1'b1;
              state       <= ERR;
            end
          end
        end
        CALC: begin
          q_w <= q_next;
          r_w <= r_next;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            quotient  <= q_next;
            remainder <= r_next;
            done_flag <= 1'b1;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign state_out = state;

  // Segment order {a,b,c,d,e,f,g}
  always_comb begin
    case (state)
      IDLE:    seg_raw = 7'b1111110;
      CALC:    seg_raw = 7'b0110000;
      DONE:    seg_raw = 7'b1101101;
      ERR:     seg_raw = 7'b1111001;
      default: seg_raw = 7'b0000000;
    endcase
  end

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} =
    seg_raw ^ {7{SEG_ACTIVE_LOW}};

endmodule

// File: tb/tb_div16x8_seq.sv
// Bench for div16x8_seq: directed table, corner sequences and random operands
// checked against plain integer division.
module tb_div16x8_seq;

  logic        clk;
  logic        arst_n;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        div_by_zero;
  logic [2:0]  state_out;
  logic        seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

  int unsigned n_pass;
  int unsigned n_total;
  logic [15:0] last_q;

  typedef struct {
    string       name;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } vec_t;

  vec_t vt [7];

  div16x8_seq #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .arst_n(arst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .done_flag(done_flag), .div_by_zero(div_by_zero),
    .state_out(state_out),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [6:0] seg_of(input logic [2:0] s);
    case (s)
      3'd0:    return 7'b1111110;
      3'd1:    return 7'b0110000;
      3'd2:    return 7'b1101101;
      3'd3:    return 7'b1111001;
      default: return 7'b0000000;
    endcase
  endfunction

  // One full operation: start edge, wait for done, check result, timing and
  // that start held high afterwards launches nothing.
  task automatic run_op(input string nm, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input logic edbz,
                        input bit disturb);
    int cyc;
    int bad_state;
    int hold_bad;
    int extra;
    cyc = 0; bad_state = 0; hold_bad = 0; extra = 0;
    @(negedge clk);
    start = 1'b0; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done_flag) break;
      if (state_out != 3'd1) bad_state++;
      if (quotient !== last_q) hold_bad++;
      if (disturb && k == 4) begin
        start = 1'b0; dividend = ~a; divisor = b + 8'd1;
      end
      if (disturb && k == 5) start = 1'b1;
      cyc++;
    end
    check({nm, " latency"}, cyc, edbz ? 0 : 16);
    check({nm, " quotient"}, quotient, eq);
    check({nm, " remainder"}, remainder, er);
    check({nm, " div_by_zero"}, div_by_zero, edbz);
    check({nm, " state at done"}, state_out, edbz ? 3'd3 : 3'd2);
    check({nm, " seg at done"}, {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g},
          seg_of(edbz ? 3'd3 : 3'd2));
    if (!edbz) begin
      check({nm, " CALC states"}, bad_state, 0);
      check({nm, " output hold"}, hold_bad, 0);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_flag || state_out != 3'd0) extra++;
    end
    check({nm, " no retrigger"}, extra, 0);
    start = 1'b0;
    last_q = eq;
  endtask

  initial begin
    n_pass = 0; n_total = 0; last_q = 16'd0;
    vt[0] = '{"basic",   16'd20000, 8'd200, 16'd100,   8'd0,   1'b0};
    vt[1] = '{"rem7",    16'd1000,  8'd7,   16'd142,   8'd6,   1'b0};
    vt[2] = '{"rem100",  16'd12345, 8'd100, 16'd123,   8'd45,  1'b0};
    vt[3] = '{"max_d1",  16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0};
    vt[4] = '{"max_d255",16'd65535, 8'd255, 16'd257,   8'd0,   1'b0};
    vt[5] = '{"small",   16'd5,     8'd9,   16'd0,     8'd5,   1'b0};
    vt[6] = '{"dbz",     16'd1234,  8'd0,   16'hFFFF,  8'hFF,  1'b1};

    arst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    check("reset quotient", quotient, 16'd0);
    check("reset remainder", remainder, 8'd0);
    check("reset done", done_flag, 1'b0);
    check("reset dbz", div_by_zero, 1'b0);
    check("reset state", state_out, 3'd0);
    check("reset seg", {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, 7'b1111110);
    @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vt[i].name, vt[i].dvd, vt[i].dvs, vt[i].q, vt[i].r, vt[i].dbz, 1'b0);

    // div_by_zero must clear on the next valid capture
    run_op("after_dbz", 16'd300, 8'd10, 16'd30, 8'd0, 1'b0, 1'b0);

    // start toggled and operands changed mid-CALC must not disturb the result
    run_op("disturb", 16'd20000, 8'd200, 16'd100, 8'd0, 1'b0, 1'b1);

    // Reset mid-operation, after a divide-by-zero left nonzero outputs
    run_op("dbz2", 16'd7, 8'd0, 16'hFFFF, 8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0; dividend = 16'd20000; divisor = 8'd200;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    repeat (8) @(negedge clk);
    check("midrst pre state", state_out, 3'd1);
    check("midrst pre hold", quotient, 16'hFFFF);
    #2 arst_n = 1'b0;
    #1;
    check("midrst quotient", quotient, 16'd0);
    check("midrst remainder", remainder, 8'd0);
    check("midrst state", state_out, 3'd0);
    check("midrst done", done_flag, 1'b0);
    check("midrst dbz", div_by_zero, 1'b0);
    start = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    last_q = 16'd0;
    run_op("post_rst", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 1'b0);

    // Random operands against plain integer division
    for (int i = 0; i < 20; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom_range(0, 65535));
      b = 8'($urandom_range(0, 255));
      if (i % 7 == 3) b = 8'd0;
      if (b == 8'd0)
        run_op("rand", a, b, 16'hFFFF, 8'hFF, 1'b1, 1'b0);
      else
        run_op("rand", a, b, a / b, 8'(a % b), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div16x8_seq.md
Name: div16x8_seq

Overview:
- Sequential restoring divider: 16-bit dividend ÷ 8-bit divisor → 16-bit quotient, 8-bit remainder.
- Produces one quotient bit per clock, under an internal FSM.
- Inverse companion of the shift-add 8x8 multiplier; a multiplier product can be fed back here for checking.
- Current FSM state is shown on a seven-segment digit, in the same style as the multiplier datapath.

Parameters:
SEG_ACTIVE_LOW, 0, 1 inverts all seg_* outputs for common-anode displays.

Ports:
clk  input  1  system clock, rising-edge.
arst_n  input  1  asynchronous active-low reset.
start  input  1  level input; an operation begins on its rising edge.
dividend  input  16  numerator, sampled at the capture edge.
divisor  input  8  denominator, sampled at the capture edge.
quotient  output  16  registered result.
remainder  output  8  registered result.
done_flag  output  1  high for exactly one cycle when a result/error is posted.
div_by_zero  output  1  sticky error flag, held until the next capture.
state_out  output  3  current FSM state code.
seg_a..seg_g  output  1 each  seven-segment decode of state_out.

Behaviour:
- Clock/reset: one clock domain (clk). Reset is asynchronous, active-low on arst_n.
- Reset values (arst_n=0, any time, including mid-operation):
  - state=IDLE; quotient=0, remainder=0.
  - done_flag=0, div_by_zero=0.
  - start_d=0; all working registers=0.
- Start detection: start_d <= start every cycle. capture = start & ~start_d & (state==IDLE).
  - Start held high through reset release therefore triggers one capture.
  - Start edges outside IDLE are ignored.
- States and codes: IDLE=0, CALC=1, DONE=2, ERR=3. Codes 4-7 are unused and recover to IDLE.
- IDLE:
  - On capture with divisor!=0: load q_w=dividend, r_w=9'd0, d_w=divisor, cnt=0; go to CALC.
  - On capture with divisor==0: go to ERR.
- CALC, every cycle:
  - t = {r_w[7:0], q_w[15]} (9 bits); q_w <= {q_w[14:0], 1'b0}.
  - If t >= {1'b0,d_w}: r_w <= t - d_w and q_w[0] <= 1. Otherwise r_w <= t.
  - cnt increments. When cnt==15, the same edge loads quotient <= final q_w and remainder <= final r_w[7:0], then goes to DONE.
- DONE: lasts one cycle, then IDLE. done_flag=1 only during this cycle.
- ERR, set on entry:
  - quotient=16'hFFFF, remainder=8'hFF, div_by_zero=1.
  - Lasts one cycle with done_flag=1, then IDLE.
- div_by_zero clears on the next capture.
- Latency: capture at edge N → 16 CALC edges (N+1..N+16) → done_flag high from edge N+16 to N+17. Divide-by-zero: done_flag high from edge N to N+1.
- Output hold: quotient/remainder keep the previous result during CALC. They update only on the DONE/ERR entry edge.
- Invariants: r_w never exceeds 8 bits after subtract, since r_w < d_w ≤ 255. The 9th bit exists only for the compare.
- Operand changes after the capture edge have no effect on the running operation.
- seg_* decode (active-high, a..g):
  - 0 = abcdef
  - 1 = bc
  - 2 = abdeg
  - 3 = abcdg
  - other codes = all off
  - Combinational from state_out; inverted when SEG_ACTIVE_LOW=1.

Test Plan:
- Basic divide:
  - Stimulus: reset, then start rising edge with dividend=20000, divisor=200.
  - Response: done_flag is a single pulse 16 cycles after capture. quotient=100, remainder=0, div_by_zero=0. state_out sequence 0,1×16,2,0.
- Nonzero remainder: dividend=1000, divisor=7 → quotient=142, remainder=6. A following operation with dividend=12345, divisor=100 → quotient=123, remainder=45.
- Extremes:
  - dividend=65535, divisor=1 → quotient=65535, remainder=0.
  - dividend=65535, divisor=255 → quotient=257, remainder=0.
  - dividend=5, divisor=9 → quotient=0, remainder=5.
- Divide by zero: dividend=1234, divisor=0 → one-cycle done_flag the cycle after capture. quotient=16'hFFFF, remainder=8'hFF, div_by_zero=1. div_by_zero clears at the next valid capture.
- Ignored restart and frozen operands:
  - During CALC, toggle start and change operands → no effect. Original result posted on schedule.
  - Holding start high after DONE → no second operation.
  - A new rising edge in IDLE → new operation starts.
- Reset mid-operation: assert arst_n=0 at CALC cycle 8 (asynchronously, between edges) → all outputs 0 and state_out=0 immediately. After release, a fresh start edge produces a correct result.
